cnt_ceil: RTL and testbench
===========================

Name: cnt_ceil

Overview:
- Programmable modulo counter.
- While enabled, it counts up from 0 to a run-time ceiling minus one, then wraps to 0.
- It raises a carry-out on the wrap cycle.
- Used as a general timebase/prescaler; the carry-out chains into the enable of a downstream counter.

Parameters:
- WIDTH, 4, bit width of cnt and ceil.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- en     input   1      count enable; counter holds when low
- ceil   input   WIDTH  modulus; counter sequence is 0..ceil-1
- cnt    output  WIDTH  current count (registered)
- co     output  1      carry-out; high during the cycle in which the counter wraps

Behaviour:
- Reset is asynchronous and active-low; the clock is clk.
  - rst_n low: cnt forced to 0 immediately, without waiting for a clock edge, and held at 0 while low.
  - co is then 0, because cnt=0 < ceil-1 is not terminal unless ceil<=1 and en=1.
  - Counting resumes on the first rising edge after rst_n is released.
- Terminal condition tc:
  - Evaluated in WIDTH+1-bit arithmetic.
  - tc = 1 when ceil <= 1, or when cnt >= ceil-1.
  - "Greater-or-equal" is required so that lowering ceil below the current count recovers on the next enabled edge rather than counting through to 2^WIDTH-1.
- co is combinational: co = en & tc. There is no registered delay. co is high for exactly the final cycle of each period.
- Rising edge of clk with rst_n high:
  - en=0: cnt holds.
  - en=1 and tc=1: cnt <= 0.
  - en=1 and tc=0: cnt <= cnt+1.
- ceil is sampled every cycle; there is no latching.
  - A change takes effect on the very next edge.
  - ceil raised above cnt: counting continues to the new ceil-1.
  - ceil lowered to <= cnt+1: wrap to 0 on the next enabled edge, with co high in that cycle.
- ceil=0 and ceil=1 both give modulus 1: cnt stays 0 and co = en.
- ceil = 2^WIDTH-1 gives period 2^WIDTH-1; full 2^WIDTH period is not reachable. This is intended.
- en deasserted on the terminal cycle: co drops, cnt holds at the terminal value, and it wraps on the next enabled edge.
- Reset mid-period: cnt returns to 0 asynchronously. The period restarts and no co is produced for the aborted period.
- No X propagation from ceil when en=0: cnt holds regardless of ceil.

Test Plan:
- Reset/hold: rst_n=1, en=0, ceil=12 for 5 edges -> cnt stays at its reset value. Then pulse rst_n=0 mid-cycle (not on an edge) -> cnt=0 immediately.
- Basic wrap: ceil=12, en=1 from 0 -> cnt 0,1,...,11,0,1...; co=1 only while cnt=11 (one cycle per 12); co=0 elsewhere.
- Async reset mid-count: counting with cnt=5, rst_n low for 1 ns between edges -> cnt=0 at once; next edge after release -> cnt=1; next co after 11 more enabled edges.
- Ceiling lowered: ceil=12, cnt=9, switch ceil to 6 -> co=1 in that cycle, next edge cnt=0. Then period 6: co high at cnt=5. Ceiling raised 6->12 at cnt=3 -> continues to 11 before wrapping.
- Enable gating: ceil=6, drop en at cnt=5 -> co=0, cnt holds 5 for 3 edges. Re-enable -> co=1 immediately, next edge cnt=0.
- Degenerate ceil: ceil=0 and ceil=1 with en=1 -> cnt=0 constantly, co=1. With en=0 -> co=0.

Source files
------------

// File: rtl/cnt_ceil.sv
// -----------------------------------------------------------------------------
// cnt_ceil -- programmable modulo counter (timebase / prescaler)
//
// While enabled, cnt runs 0, 1, ..., ceil-1 and then wraps back to 0.
// co is high, combinationally, during the cycle in which the wrap will happen.
// That makes co usable directly as the enable of a downstream counter.
// ceil is not latched: it is looked at on every cycle. ceil = 0 and ceil = 1
// both give a modulus of 1.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset (forces cnt to 0)
//   en     in   1      count enable; cnt holds while low
//   ceil   in   WIDTH  modulus; sequence is 0..ceil-1
//   cnt    out  WIDTH  current count (registered)
//   co     out  1      carry-out, en & terminal
// -----------------------------------------------------------------------------
module cnt_ceil #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] ceil,
  output logic [WIDTH-1:0] cnt,
  output logic             co
);

  localparam logic [WIDTH:0]   EXT_ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH:0]   ceil_ext;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   last_ext;
  logic             small_ceil;
  logic             tc;

  // The compare uses one extra bit so that ceil-1 cannot underflow.
  assign ceil_ext   = {1'b0, ceil};
  assign cnt_ext    = {1'b0, cnt_reg};
  assign last_ext   = ceil_ext - EXT_ONE;
  assign small_ceil = (ceil_ext <= EXT_ONE);

  // The terminal test is >= rather than ==. If ceil is lowered below the
  // current count, the counter wraps on the next enabled edge. It does not
  // run on up to the all-ones value first.
  assign tc = small_ceil | (cnt_ext >= last_ext);

  assign co = en & tc;

  always_comb begin
    cnt_next = cnt_reg;
    if (en) begin
      if (tc) cnt_next = '0;
      else    cnt_next = cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: tb/tb_cnt_ceil.sv
// -----------------------------------------------------------------------------
// tb_cnt_ceil -- self-checking bench for cnt_ceil (WIDTH = 4)
//
// Each cycle the bench drives en and ceil just after a rising edge. It pushes
// the expected (cnt, co) for that cycle onto a queue. On the following falling
// edge it pops the entry and compares it with the DUT outputs.
// The reference model is a plain period counter kept by the bench.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cnt_ceil;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] ceil;
  logic [3:0] cnt;
  logic       co;

  cnt_ceil #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .ceil  (ceil),
    .cnt   (cnt),
    .co    (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    cnt;
    int    co;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cnt = 0;   // reference model count

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected co: this is the last count of the current period.
  function automatic int model_co(input int e, input int c, input int mc);
    int period;
    period = (c <= 1) ? 1 : c;
    return (e != 0 && mc + 1 >= period) ? 1 : 0;
  endfunction

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle(input logic e, input logic [3:0] c, input string tag);
    exp_t x;
    exp_t y;
    en   = e;
    ceil = c;
    x.tag = tag;
    x.cnt = m_cnt;
    x.co  = model_co(int'(e), int'(c), m_cnt);
    sb_q.push_back(x);
    @(negedge clk);
    y = sb_q.pop_front();
    check({y.tag, ".cnt"}, int'(cnt), y.cnt);
    check({y.tag, ".co"},  int'(co),  y.co);
    $display("cyc %-10s en=%0d ceil=%2d cnt=%2d co=%0d (exp cnt=%2d co=%0d)",
             tag, e, c, cnt, co, y.cnt, y.co);
    @(posedge clk);
    if (e) m_cnt = (x.co != 0) ? 0 : m_cnt + 1;
    #1;
  endtask

  // Pulse reset between clock edges and check that cnt clears at once.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    m_cnt = 0;
    check({tag, ".cnt"}, int'(cnt), 0);
    check({tag, ".co"},  int'(co),  model_co(int'(en), int'(ceil), 0));
    $display("rst %-10s cnt=%2d co=%0d", tag, cnt, co);
    #1 rst_n = 1'b1;
  endtask

  // Advance with en=1 until the model reaches target (bounded).
  task automatic run_to(input int target, input logic [3:0] c, input string tag);
    int k;
    k = 0;
    while (m_cnt != target && k < 40) begin
      cycle(1'b1, c, tag);
      k++;
    end
    if (m_cnt != target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.timeout: model at %0d, wanted %0d", tag, m_cnt, target);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    ceil  = 4'd12;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_cnt = 0;

    // Reset and hold
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'd12, "hold");
    async_reset("rst_idle");

    // Basic wrap with modulus 12
    for (int i = 0; i < 26; i++) cycle(1'b1, 4'd12, "wrap12");

    // Asynchronous reset in the middle of a count
    run_to(5, 4'd12, "to5");
    async_reset("rst_mid");
    for (int i = 0; i < 13; i++) cycle(1'b1, 4'd12, "after_rst");

    // Ceiling lowered below the current count, then raised again
    run_to(9, 4'd12, "to9");
    cycle(1'b1, 4'd6, "lower6");
    for (int i = 0; i < 9; i++) cycle(1'b1, 4'd6, "per6");
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'd12, "raise12");

    // Enable gating on the terminal cycle
    run_to(5, 4'd6, "to5_c6");
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd6, "gated");
    cycle(1'b1, 4'd6, "reen");
    cycle(1'b1, 4'd6, "reen_wrap");

    // Degenerate ceilings 0 and 1
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'd0, "ceil0_en");
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'd0, "ceil0_dis");
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'd1, "ceil1_en");
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'd1, "ceil1_dis");

    // Largest ceiling: period 15
    for (int i = 0; i < 17; i++) cycle(1'b1, 4'd15, "ceil15");

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
